// File: rtl/fust_issue_table_pkg.sv
// ---------------------------------------------------------------------------
// fust_issue_table_pkg
//   Shared types and constants for the functional-unit status table (FUST).
//   - Table geometry (NUM_FU rows, NUM_SRC sources, field widths)
//   - fust_state_e : per-row lifecycle state
//   - fust_row_t   : one row's captured dispatch fields and producer tags
//   - FU index constants (tag value = producing FU index)
//   - tag_hit()    : does a writeback vector broadcast a given producer tag
// ---------------------------------------------------------------------------
package fust_issue_table_pkg;

    localparam int NUM_FU  = 5;
    localparam int NUM_SRC = 3;
    localparam int REG_W   = 5;
    localparam int OP_W    = 8;
    localparam int FU_W    = $clog2(NUM_FU);

    typedef enum logic [1:0] {
        FUST_IDLE   = 2'd0,
        FUST_WAIT   = 2'd1,
        FUST_READY  = 2'd2,
        FUST_ISSUED = 2'd3
    } fust_state_e;

    typedef struct packed {
        logic [OP_W-1:0]               op;
        logic [REG_W-1:0]              rd;
        logic [NUM_SRC-1:0][REG_W-1:0] rs;
        logic [NUM_SRC-1:0]            tvld;
        logic [NUM_SRC-1:0][FU_W-1:0]  tag;
        logic                          spec;
    } fust_row_t;

    localparam logic [FU_W-1:0] FU_ALU  = FU_W'(0);
    localparam logic [FU_W-1:0] FU_LS   = FU_W'(1);
    localparam logic [FU_W-1:0] FU_MAT  = FU_W'(2);
    localparam logic [FU_W-1:0] FU_GEMM = FU_W'(3);
    localparam logic [FU_W-1:0] FU_VEC  = FU_W'(4);

    // One-hot decode of the tag against the writeback strobes, so tags that
    // name no real FU simply never match.
    function automatic logic tag_hit(input logic [FU_W-1:0] tag,
                                     input logic [NUM_FU-1:0] wb);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (tag == FU_W'(k)) hit = hit | wb[k];
        end
        return hit;
    endfunction

endpackage

// File: rtl/fust_issue_table_if.sv
// ---------------------------------------------------------------------------
// fust_issue_table_if
//   Dispatch / writeback / branch / issue bundle of the FUST.
//   master : dispatch stage + FU side (drives requests, wakeups, fu_ready)
//   slave  : the table itself (drives disp_ready, issue strobes, row state)
// ---------------------------------------------------------------------------
interface fust_issue_table_if;
    import fust_issue_table_pkg::*;

    logic                                disp_valid;
    logic                                disp_ready;
    logic [FU_W-1:0]                     disp_fu;
    logic [OP_W-1:0]                     disp_op;
    logic [REG_W-1:0]                    disp_rd;
    logic [NUM_SRC*REG_W-1:0]            disp_rs;
    logic [NUM_SRC-1:0]                  disp_tvld;
    logic [NUM_SRC*FU_W-1:0]             disp_tag;
    logic                                disp_spec;
    logic [NUM_FU-1:0]                   wb_valid;
    logic [NUM_FU-1:0]                   fu_ready;
    logic                                branch_resolved;
    logic                                branch_miss;
    logic [NUM_FU-1:0]                   iss_valid;
    logic [NUM_FU-1:0][OP_W-1:0]         iss_op;
    logic [NUM_FU-1:0][REG_W-1:0]        iss_rd;
    logic [NUM_FU-1:0][NUM_SRC*REG_W-1:0] iss_rs;
    logic [NUM_FU*2-1:0]                 fust_state;

    modport master (
        output disp_valid, disp_fu, disp_op, disp_rd, disp_rs, disp_tvld, disp_tag,
               disp_spec, wb_valid, fu_ready, branch_resolved, branch_miss,
        input  disp_ready, iss_valid, iss_op, iss_rd, iss_rs, fust_state
    );

    modport slave (
        input  disp_valid, disp_fu, disp_op, disp_rd, disp_rs, disp_tvld, disp_tag,
               disp_spec, wb_valid, fu_ready, branch_resolved, branch_miss,
        output disp_ready, iss_valid, iss_op, iss_rd, iss_rs, fust_state
    );

endinterface

// File: rtl/fust_issue_table_wakeup.sv
// ---------------------------------------------------------------------------
// fust_issue_table_wakeup (fust_wakeup role)
//   One row's producer-tag comparators against the writeback broadcast.
//   tvld_i/tag_i : row's registered tag state
//   wb_valid_i   : FU completion strobes
//   tvld_o       : tag-valid vector after this cycle's wakeups
//   all_clear_o  : no source still waits after this cycle's wakeups
// ---------------------------------------------------------------------------
module fust_issue_table_wakeup
    import fust_issue_table_pkg::*;
(
    input  logic [NUM_SRC-1:0]           tvld_i,
    input  logic [NUM_SRC-1:0][FU_W-1:0] tag_i,
    input  logic [NUM_FU-1:0]            wb_valid_i,
    output logic [NUM_SRC-1:0]           tvld_o,
    output logic                         all_clear_o
);

    always_comb begin
        tvld_o = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            tvld_o[s] = tvld_i[s] & ~tag_hit(tag_i[s], wb_valid_i);
        end
    end

    assign all_clear_o = ~|tvld_o;

endmodule

// File: rtl/fust_issue_table.sv
// ---------------------------------------------------------------------------
// fust_issue_table
//   Functional-unit status table: one row per FU between dispatch and issue,
//   with tag wakeup from FU writebacks and single-branch speculation.
//   CLK  : clock, rising edge
//   nRST : asynchronous reset, active low
//   bus  : fust_issue_table_if.slave (dispatch, writeback, branch, issue, state)
//   Build option FUST_WAKEUP_BYPASS_EN: a WAIT row whose last tag clears this
//   cycle may issue in the same cycle instead of waiting for registered READY.
// ---------------------------------------------------------------------------
module fust_issue_table
    import fust_issue_table_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    fust_issue_table_if.slave bus
);

    fust_row_t          row_q [NUM_FU];
    fust_row_t          row_d [NUM_FU];
    fust_state_e        st_q  [NUM_FU];
    fust_state_e        st_d  [NUM_FU];
    logic [NUM_SRC-1:0] tvld_nx [NUM_FU];
    logic [NUM_FU-1:0]  all_clr;
    logic [NUM_FU-1:0]  iss_vld;
    logic [NUM_FU-1:0]  squash;
    logic               br_miss;
    logic               disp_rdy;
    logic               disp_acc;
    fust_row_t          disp_row;

    logic [NUM_FU-1:0][OP_W-1:0]          iss_op_w;
    logic [NUM_FU-1:0][REG_W-1:0]         iss_rd_w;
    logic [NUM_FU-1:0][NUM_SRC*REG_W-1:0] iss_rs_w;
    logic [NUM_FU*2-1:0]                  state_w;

    assign br_miss = bus.branch_resolved & bus.branch_miss;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_wake
        fust_issue_table_wakeup u_wake (
            .tvld_i      (row_q[g].tvld),
            .tag_i       (row_q[g].tag),
            .wb_valid_i  (bus.wb_valid),
            .tvld_o      (tvld_nx[g]),
            .all_clear_o (all_clr[g])
        );
    end

    // Only registered state gates acceptance; an out-of-range index matches no row.
    always_comb begin
        disp_rdy = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (bus.disp_fu == FU_W'(k) && st_q[k] == FUST_IDLE) disp_rdy = 1'b1;
        end
    end

    // A speculative dispatch arriving with the miss would be squashed anyway.
    assign disp_acc = bus.disp_valid & disp_rdy & ~(bus.disp_spec & br_miss);

    // Incoming row, with tags already woken by this cycle's writebacks.
    always_comb begin
        disp_row      = '0;
        disp_row.op   = bus.disp_op;
        disp_row.rd   = bus.disp_rd;
        for (int s = 0; s < NUM_SRC; s++) begin
            disp_row.rs[s]   = bus.disp_rs[s*REG_W +: REG_W];
            disp_row.tag[s]  = bus.disp_tag[s*FU_W +: FU_W];
            disp_row.tvld[s] = bus.disp_tvld[s] & ~tag_hit(disp_row.tag[s], bus.wb_valid);
        end
        disp_row.spec = bus.disp_spec & ~bus.branch_resolved;
    end

    always_comb begin
        iss_vld = '0;
        squash  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            // ISSUED rows are left to drain; only not-yet-issued spec rows die.
            squash[k] = br_miss & row_q[k].spec &
                        (st_q[k] == FUST_WAIT || st_q[k] == FUST_READY);
`ifdef FUST_WAKEUP_BYPASS_EN
            iss_vld[k] = ((st_q[k] == FUST_READY) || (st_q[k] == FUST_WAIT && all_clr[k]))
                         & bus.fu_ready[k] & ~squash[k];
`else
            iss_vld[k] = (st_q[k] == FUST_READY) & bus.fu_ready[k] & ~squash[k];
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            row_d[k]      = row_q[k];
            row_d[k].tvld = tvld_nx[k];
            if (bus.branch_resolved) row_d[k].spec = 1'b0;
            st_d[k] = st_q[k];
            case (st_q[k])
                FUST_WAIT:   if (all_clr[k]) st_d[k] = FUST_READY;
                FUST_ISSUED: if (bus.wb_valid[k]) st_d[k] = FUST_IDLE;
                default: ;
            endcase
            if (iss_vld[k]) st_d[k] = FUST_ISSUED;
            if (squash[k])  st_d[k] = FUST_IDLE;
            if (disp_acc && bus.disp_fu == FU_W'(k)) begin
                row_d[k] = disp_row;
                st_d[k]  = (|disp_row.tvld) ? FUST_WAIT : FUST_READY;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NUM_FU; k++) begin
                row_q[k] <= '0;
                st_q[k]  <= FUST_IDLE;
            end
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                row_q[k] <= row_d[k];
                st_q[k]  <= st_d[k];
            end
        end
    end

    always_comb begin
        iss_op_w = '0;
        iss_rd_w = '0;
        iss_rs_w = '0;
        state_w  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (iss_vld[k]) begin
                iss_op_w[k] = row_q[k].op;
                iss_rd_w[k] = row_q[k].rd;
                iss_rs_w[k] = row_q[k].rs;
            end
            state_w[2*k +: 2] = st_q[k];
        end
    end

    assign bus.disp_ready = disp_rdy;
    assign bus.iss_valid  = iss_vld;
    assign bus.iss_op     = iss_op_w;
    assign bus.iss_rd     = iss_rd_w;
    assign bus.iss_rs     = iss_rs_w;
    assign bus.fust_state = state_w;

endmodule

// File: tb/tb_fust_issue_table.sv
// ---------------------------------------------------------------------------
// tb_fust_issue_table
//   Directed scenarios plus a randomized run, each cycle compared against a
//   row-level behavioural model of the table.
// ---------------------------------------------------------------------------
module tb_fust_issue_table;
    import fust_issue_table_pkg::*;

    localparam int S_IDLE = 0, S_WAIT = 1, S_READY = 2, S_ISSUED = 3;

    logic CLK;
    logic nRST;
    fust_issue_table_if bus();

    fust_issue_table dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: per row a lifecycle code, pending-source flags,
    // producer tags, spec flag and captured fields.
    int          mst   [NUM_FU];
    bit          mpend [NUM_FU][NUM_SRC];
    int          mtag  [NUM_FU][NUM_SRC];
    bit          mspec [NUM_FU];
    logic [7:0]  mop   [NUM_FU];
    logic [4:0]  mrd   [NUM_FU];
    logic [14:0] mrs   [NUM_FU];
    int          nst   [NUM_FU];
    bit          npend [NUM_FU][NUM_SRC];
    int          ntag  [NUM_FU][NUM_SRC];
    bit          nspec [NUM_FU];
    logic [7:0]  nop   [NUM_FU];
    logic [4:0]  nrd   [NUM_FU];
    logic [14:0] nrs   [NUM_FU];
    logic [4:0]  exp_iss;
    bit          exp_drdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_FU; k++) begin
            mst[k] = S_IDLE; mspec[k] = 0; mop[k] = '0; mrd[k] = '0; mrs[k] = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                mpend[k][s] = 0; mtag[k][s] = 0;
            end
        end
    endtask

    function automatic logic [9:0] pack_state();
        logic [9:0] v;
        v = '0;
        for (int k = 0; k < NUM_FU; k++) v[2*k +: 2] = 2'(mst[k]);
        return v;
    endfunction

    task automatic model_eval();
        bit miss, left, sq, can;
        int f;
        miss = bus.branch_resolved && bus.branch_miss;
        exp_iss = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            left = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                ntag[k][s]  = mtag[k][s];
                npend[k][s] = mpend[k][s] && !bus.wb_valid[mtag[k][s]];
                if (npend[k][s]) left = 1;
            end
            sq  = miss && mspec[k] && (mst[k] == S_WAIT || mst[k] == S_READY);
            can = (mst[k] == S_READY);
`ifdef FUST_WAKEUP_BYPASS_EN
            if (mst[k] == S_WAIT && !left) can = 1;
`endif
            exp_iss[k] = can && bus.fu_ready[k] && !sq;
            nst[k] = mst[k];
            if (sq) nst[k] = S_IDLE;
            else if (exp_iss[k]) nst[k] = S_ISSUED;
            else if (mst[k] == S_WAIT && !left) nst[k] = S_READY;
            else if (mst[k] == S_ISSUED && bus.wb_valid[k]) nst[k] = S_IDLE;
            nspec[k] = mspec[k] && !bus.branch_resolved;
            nop[k] = mop[k]; nrd[k] = mrd[k]; nrs[k] = mrs[k];
        end
        f = int'(bus.disp_fu);
        exp_drdy = 0;
        if (f < NUM_FU) exp_drdy = (mst[f] == S_IDLE);
        if (bus.disp_valid && exp_drdy && !(bus.disp_spec && miss)) begin
            left = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                ntag[f][s]  = int'(bus.disp_tag[s*3 +: 3]);
                npend[f][s] = bus.disp_tvld[s] && !bus.wb_valid[ntag[f][s]];
                if (npend[f][s]) left = 1;
            end
            nst[f]   = left ? S_WAIT : S_READY;
            nspec[f] = bus.disp_spec && !bus.branch_resolved;
            nop[f] = bus.disp_op; nrd[f] = bus.disp_rd; nrs[f] = bus.disp_rs;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("disp_ready", 32'(bus.disp_ready), 32'(exp_drdy));
        chk("iss_valid", 32'(bus.iss_valid), 32'(exp_iss));
        chk("fust_state", 32'(bus.fust_state), 32'(pack_state()));
        for (int k = 0; k < NUM_FU; k++) begin
            if (exp_iss[k]) begin
                chk($sformatf("iss_op[%0d]", k), 32'(bus.iss_op[k]), 32'(mop[k]));
                chk($sformatf("iss_rd[%0d]", k), 32'(bus.iss_rd[k]), 32'(mrd[k]));
                chk($sformatf("iss_rs[%0d]", k), 32'(bus.iss_rs[k]), 32'(mrs[k]));
            end
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        mst = nst; mpend = npend; mtag = ntag; mspec = nspec;
        mop = nop; mrd = nrd; mrs = nrs;
        @(negedge CLK);
    endtask

    task automatic cyc(input bit dv, input logic [2:0] fu, input logic [2:0] tv,
                       input logic [8:0] tg, input bit sp, input logic [4:0] wb,
                       input logic [4:0] fr, input bit br, input bit bm);
        bus.disp_valid      = dv;
        bus.disp_fu         = fu;
        bus.disp_tvld       = tv;
        bus.disp_tag        = tg;
        bus.disp_spec       = sp;
        bus.disp_op         = 8'($urandom);
        bus.disp_rd         = 5'($urandom);
        bus.disp_rs         = 15'($urandom);
        bus.wb_valid        = wb;
        bus.fu_ready        = fr;
        bus.branch_resolved = br;
        bus.branch_miss     = bm;
        settle();
    endtask

    task automatic idle(input logic [4:0] wb, input logic [4:0] fr);
        cyc(1'b0, 3'd0, 3'd0, 9'd0, 1'b0, wb, fr, 1'b0, 1'b0);
    endtask

    initial begin
        logic [8:0] tg;
        logic [4:0] wbr;
        nRST = 1'b0;
        bus.disp_valid = 0; bus.disp_fu = '0; bus.disp_op = '0; bus.disp_rd = '0;
        bus.disp_rs = '0; bus.disp_tvld = '0; bus.disp_tag = '0; bus.disp_spec = 0;
        bus.wb_valid = '0; bus.fu_ready = '0; bus.branch_resolved = 0; bus.branch_miss = 0;
        model_reset();
        #3;
        chk("rst disp_ready", 32'(bus.disp_ready), 32'd1);
        chk("rst iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("rst fust_state", 32'(bus.fust_state), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // 1: untagged dispatch to row 0, issue, writeback
        cyc(1'b1, FU_ALU, 3'b000, 9'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("t1 disp_ready", 32'(bus.disp_ready), 32'd1);
        adv();
        idle(5'd0, 5'b00001);
        chk("t1 iss_valid", 32'(bus.iss_valid), 32'h01);
        chk("t1 ready", 32'(bus.fust_state[1:0]), 32'(S_READY));
        adv();
        idle(5'b00001, 5'd0);
        chk("t1 issued", 32'(bus.fust_state[1:0]), 32'(S_ISSUED));
        adv();
        idle(5'd0, 5'd0);
        chk("t1 idle", 32'(bus.fust_state[1:0]), 32'(S_IDLE));
        adv();

        // 2: row 2 waits on FU0 (src1) and FU1 (src2)
        cyc(1'b1, FU_MAT, 3'b110, {3'd1, 3'd0, 3'd0}, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        adv();
        idle(5'b00001, 5'd0);
        chk("t2 wait N", 32'(bus.fust_state[5:4]), 32'(S_WAIT));
        adv();
        idle(5'd0, 5'd0); adv();
        idle(5'd0, 5'd0); adv();
        idle(5'b00010, 5'b00100);
        chk("t2 wait N+3", 32'(bus.fust_state[5:4]), 32'(S_WAIT));
`ifdef FUST_WAKEUP_BYPASS_EN
        chk("t2 bypass iss N+3", 32'(bus.iss_valid), 32'h04);
`else
        chk("t2 no iss N+3", 32'(bus.iss_valid), 32'h00);
`endif
        adv();
        idle(5'd0, 5'b00100);
`ifdef FUST_WAKEUP_BYPASS_EN
        chk("t2 issued N+4", 32'(bus.fust_state[5:4]), 32'(S_ISSUED));
`else
        chk("t2 ready N+4", 32'(bus.fust_state[5:4]), 32'(S_READY));
        chk("t2 iss N+4", 32'(bus.iss_valid), 32'h04);
`endif
        adv();
        idle(5'b00100, 5'd0); adv();

        // 3: dispatch/wakeup collision
        cyc(1'b1, FU_LS, 3'b001, {6'd0, FU_LS}, 1'b0, 5'b00010, 5'd0, 1'b0, 1'b0);
        adv();
        idle(5'd0, 5'b00010);
        chk("t3 ready", 32'(bus.fust_state[3:2]), 32'(S_READY));
        adv();
        idle(5'b00010, 5'd0); adv();

        // 4: branch miss squash
        cyc(1'b1, FU_GEMM, 3'b000, 9'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); adv();
        cyc(1'b1, FU_VEC, 3'b000, 9'd0, 1'b1, 5'd0, 5'b01000, 1'b0, 1'b0); adv();
        cyc(1'b1, FU_LS, 3'b001, {6'd0, FU_MAT}, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); adv();
        cyc(1'b1, FU_ALU, 3'b000, 9'd0, 1'b1, 5'd0, 5'b11111, 1'b1, 1'b1);
        chk("t4 pre state", 32'(bus.fust_state), 32'h2C4);
        chk("t4 iss suppressed", 32'(bus.iss_valid), 32'h00);
        adv();
        idle(5'b01000, 5'd0);
        chk("t4 post state", 32'(bus.fust_state), 32'h0C0);
        adv();
        idle(5'd0, 5'd0);
        chk("t4 drained", 32'(bus.fust_state), 32'h000);
        adv();

        // 5: async reset mid-WAIT with an issue in flight
        cyc(1'b1, FU_MAT, 3'b001, {6'd0, FU_GEMM}, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); adv();
        cyc(1'b1, FU_ALU, 3'b000, 9'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); adv();
        idle(5'd0, 5'b00001);
        chk("t5 iss before rst", 32'(bus.iss_valid), 32'h01);
        #1 nRST = 1'b0;
        #1;
        chk("t5 rst iss_valid", 32'(bus.iss_valid), 32'h00);
        chk("t5 rst fust_state", 32'(bus.fust_state), 32'h000);
        chk("t5 rst disp_ready", 32'(bus.disp_ready), 32'd1);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        cyc(1'b1, FU_MAT, 3'b000, 9'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("t5 disp after rst", 32'(bus.disp_ready), 32'd1);
        adv();
        idle(5'd0, 5'd0);
        chk("t5 ready after rst", 32'(bus.fust_state), 32'h020);
        adv();
        idle(5'd0, 5'b00100); adv();
        idle(5'b00100, 5'd0); adv();

        // 6: correct resolve clears spec bits, later miss leaves rows alone
        cyc(1'b1, FU_VEC, 3'b001, {6'd0, FU_GEMM}, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0); adv();
        cyc(1'b1, FU_LS, 3'b000, 9'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0); adv();
        cyc(1'b0, 3'd0, 3'd0, 9'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
        chk("t6 pre miss", 32'(bus.fust_state), 32'h108);
        adv();
        idle(5'd0, 5'd0);
        chk("t6 survives miss", 32'(bus.fust_state), 32'h108);
        adv();
        idle(5'b01000, 5'd0); adv();
        idle(5'd0, 5'b11111); adv();
        idle(5'b11111, 5'd0); adv();

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            for (int s = 0; s < NUM_SRC; s++) tg[s*3 +: 3] = 3'($urandom_range(0, 4));
            for (int k = 0; k < NUM_FU; k++) wbr[k] = ($urandom_range(0, 3) == 0);
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom), tg,
                1'($urandom_range(0, 1)), wbr, 5'($urandom),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
